// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Clear-sequencer states, index-width helper and the reset fill value.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } rf_state_e;

  localparam logic [63:0] ZERO_VAL = 64'd0;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set when decode issues a producer, cleared on writeback.
// Allocation beats a same-cycle write because it names a newer producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_en,
  input  logic [NWRITE-1:0]    i_we,
  input  logic [NWRITE*AW-1:0] i_rd,
  input  logic                 i_alloc_en,
  input  logic [AW-1:0]        i_alloc_rd,
  input  logic [NREAD*AW-1:0]  i_rs,
  output logic [NREAD-1:0]     o_rs_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             alloc;

  assign alloc = i_en && i_alloc_en && (i_alloc_rd != '0);

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (i_we[w]) busy_d[i_rd[w*AW +: AW]] = 1'b0;
    end
    if (alloc) busy_d[i_alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) busy_q <= '0;
    else           busy_q <= busy_d;
  end

  // i_we arrives pre-qualified, so a bypassed write drops the hazard
  always_comb begin
    o_rs_busy = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (i_en) o_rs_busy[p] = busy_q[i_rs[p*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (i_we[w] &&
              i_rd[w*AW +: AW] == i_rs[p*AW +: AW] &&
              !(alloc && i_alloc_rd == i_rs[p*AW +: AW]))
            o_rs_busy[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 tied to zero, optional write bypass,
// busy scoreboard and a post-reset clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic [NREAD*AW-1:0]    i_rs,
  output logic [NREAD*XLEN-1:0]  o_rs_value,
  output logic [NREAD-1:0]       o_rs_busy,
  input  logic [NWRITE-1:0]      i_we,
  input  logic [NWRITE*AW-1:0]   i_rd,
  input  logic [NWRITE*XLEN-1:0] i_wdata,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_rd,
  output logic                   o_ready
);

  localparam logic [AW-1:0]   LAST = AW'(NREGS - 1);
  localparam logic [XLEN-1:0] ZERO = XLEN'(ZERO_VAL);

  rf_state_e         state_q;
  rf_state_e         state_d;
  logic [AW-1:0]     clr_ptr_q;
  logic [AW-1:0]     clr_ptr_d;
  logic              clr_we;
  logic              ready;
  logic [NWRITE-1:0] wr_en;
  logic [XLEN-1:0]   regs [NREGS];

  assign ready   = (state_q == READY);
  assign o_ready = ready;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) state_d = READY;
      end
      READY: ;
      default: ;
    endcase
  end

  always_comb begin
    wr_en = '0;
    for (int w = 0; w < NWRITE; w++) begin
      wr_en[w] = ready && i_resetn && i_we[w] &&
                 (i_rd[w*AW +: AW] != '0);
    end
  end

  // later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge i_clk) begin
    if (i_resetn && clr_we) regs[clr_ptr_q] <= ZERO;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en[w])
        regs[i_rd[w*AW +: AW]] <= i_wdata[w*XLEN +: XLEN];
    end
  end

  always_comb begin
    o_rs_value = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (ready && i_rs[p*AW +: AW] != '0) begin
        o_rs_value[p*XLEN +: XLEN] = regs[i_rs[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && i_rd[w*AW +: AW] == i_rs[p*AW +: AW])
              o_rs_value[p*XLEN +: XLEN] = i_wdata[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_en       (ready),
    .i_we       (wr_en),
    .i_rd       (i_rd),
    .i_alloc_en (i_alloc_en),
    .i_alloc_rd (i_alloc_rd),
    .i_rs       (i_rs),
    .o_rs_busy  (o_rs_busy)
  );

endmodule
